fwd_hazard_unit: RTL and testbench
==================================

// Module: fwd_hazard_unit
// PURPOSE
//  Parametrised forwarding and hazard controller for the ARM pipeline (IF/ID/EXE/MEM/WB).
//  Tracks in-flight destinations in an internal tag shift register, so stage dest inputs are not needed.
//  At ID->EXE advance, computes registered bypass selects for N_SRC EXE operands.
//  Raises a stall for load-use (LOAD_LAT-aware) hazards. Bubbles are inserted on stall and flush.
// PARAMETERS
//  REG_AW    4  register address width (16 ARM regs)
//  N_SRC     3  source operands per instr (val1, val2, store value)
//  DEPTH     2  forwarding stages after EXE (1=MEM, 2=WB); >=1
//  LOAD_LAT  1  extra stages before load data is forwardable; 0 <= LOAD_LAT < DEPTH
//  SW        $clog2(DEPTH+1) (localparam) select width per operand
// PORTS
//  clk           in   1             clock
//  rst           in   1             synchronous reset, active-high
//  freeze        in   1             global pipeline hold (memory wait); all state holds
//  flush         in   1             branch taken in EXE; kill ID instr
//  id_valid      in   1             ID holds a real instruction
//  id_src        in   N_SRC*REG_AW  ID source regs, operand i at [i*REG_AW +: REG_AW]
//  id_src_used   in   N_SRC         operand i actually read (immediates clear it)
//  id_dest       in   REG_AW        ID destination reg
//  id_wb_en      in   1             ID instr writes the register file
//  id_mem_read   in   1             ID instr is a load (LDR)
//  hazard_stall  out  1             hold PC and IF/ID; bubble into EXE (combinational)
//  exe_sel       out  N_SRC*SW      EXE operand select: 0 = reg file, k = stage k (1=MEM, 2=WB)
// BEHAVIOUR
//  - Tag array T[0..DEPTH-1] = {valid, wb_en, dest, is_load}. T[0] = EXE, T[1] = MEM, ...
//  - Reset: all T invalid, exe_sel = 0, hazard_stall = 0. A reset mid-stream discards all tags.
//  - match(i,j) = id_valid & id_src_used[i] & T[j].valid & T[j].wb_en & id_src[i]==T[j].dest.
//  - Stall: hazard_stall = !flush & OR over i,j of match(i,j) & T[j].is_load & (j < LOAD_LAT).
//  - Advance when !freeze:
//    - T[0] <= new tag if id_valid & !hazard_stall & !flush, else bubble (valid=0).
//    - T[k] <= T[k-1].
//  - exe_sel[i] when !freeze:
//    - On insert: smallest j in 0..DEPTH-1 with match(i,j), registered as j+1.
//    - No match: 0. The youngest producer wins.
//    - A producer leaving T[DEPTH-1] is written to the reg file (negedge write); the ID read is correct.
//    - On bubble: exe_sel <= 0.
//  - freeze=1: T, exe_sel and hazard_stall hold. flush overrides the stall (hazard_stall forced 0).
//  - Simultaneous stall and freeze: freeze wins; the stall re-evaluates after release.
//  - Latency: exe_sel is valid the cycle the instr is in EXE. Load-use costs LOAD_LAT bubbles.
//  - Tag with wb_en=0 or valid=0 never matches. Equal dest in two stages: the lower j wins.
// CONFIGURATION
//  HAZARD_FWD_EN defined: forwarding as above.
//  HAZARD_FWD_EN undefined: exe_sel is constant 0.
//    - hazard_stall = !flush & OR over i and j in 0..DEPTH-1 of match(i,j), regardless of is_load.
//    - The instr waits in ID until the producer has left T[DEPTH-1].
// TESTING
//  1 EXE->EXE: ADD r1; next ADD r2,r1,r3 -> no stall; consumer in EXE has exe_sel[0]=1, exe_sel[1]=0.
//  2 WB bypass: ADD r1; NOP; SUB r4,r1,r1 -> exe_sel[0]=2, exe_sel[1]=2, no stall.
//  3 Load-use: LDR r5; next ADD r6,r5,#1 -> hazard_stall=1 for 1 cycle.
//    - Then one bubble in EXE (exe_sel=0), then the ADD with exe_sel[0]=2.
//  4 Priority and gating: ADD r1; ADD r1; MOV r2,r1.
//    - Result: exe_sel[0]=1 (youngest).
//    - With id_src_used[1]=0 and id_src[1]=r1: exe_sel[1]=0.
//  5 Freeze/flush: freeze=1 for 3 cycles mid-dependency -> exe_sel and T hold.
//    - flush with a load-use pending -> hazard_stall=0 and a bubble is inserted.
//  6 No-fwd build, without HAZARD_FWD_EN: ADD r1; ADD r2,r1,r1.
//    - Result: stall for 2 cycles (DEPTH=2), then exe_sel=0.
//    - Reset mid-stall -> hazard_stall=0 next cycle.

Source files
------------

// File: rtl/fwd_hazard_if.sv
// ID-stage request and EXE-bypass response bundle for fwd_hazard_unit.
// The master drives the ID-stage fields; the slave (the hazard unit) returns stall and bypass selects.
interface fwd_hazard_if #(
    parameter int unsigned REG_AW = 4,
    parameter int unsigned N_SRC  = 3,
    parameter int unsigned DEPTH  = 2
);
    localparam int unsigned SW = $clog2(DEPTH + 1);

    logic                    freeze;
    logic                    flush;
    logic                    id_valid;
    logic [N_SRC*REG_AW-1:0] id_src;
    logic [N_SRC-1:0]        id_src_used;
    logic [REG_AW-1:0]       id_dest;
    logic                    id_wb_en;
    logic                    id_mem_read;
    logic                    hazard_stall;
    logic [N_SRC*SW-1:0]     exe_sel;

    modport master (
        output freeze, flush, id_valid, id_src, id_src_used, id_dest, id_wb_en, id_mem_read,
        input  hazard_stall, exe_sel
    );

    modport slave (
        input  freeze, flush, id_valid, id_src, id_src_used, id_dest, id_wb_en, id_mem_read,
        output hazard_stall, exe_sel
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding / load-use hazard controller driven by an internal tag pipeline (T[0]=EXE ... T[DEPTH-1]).
// Optional feature macro: HAZARD_FWD_EN (bypass selects); when undefined, every RAW hazard stalls.
module fwd_hazard_unit #(
    parameter int unsigned REG_AW   = 4,
    parameter int unsigned N_SRC    = 3,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned LOAD_LAT = 1
) (
    input logic         clk,
    input logic         rst,
    fwd_hazard_if.slave bus
);
`ifdef HAZARD_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif
    // Without bypassing, any in-flight producer blocks the consumer until it retires.
    localparam int unsigned STALL_DEPTH = FWD_EN ? LOAD_LAT : DEPTH;

    logic [DEPTH-1:0]             t_valid;
    logic [DEPTH-1:0]             t_wb_en;
    logic [DEPTH-1:0]             t_is_load;
    logic [DEPTH-1:0][REG_AW-1:0] t_dest;
    logic [N_SRC-1:0][DEPTH-1:0]  match;
    logic                         stall_any;
    logic                         insert;

    // RAW match of every ID operand against every in-flight tag
    always_comb begin
        match = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                match[i][j] = bus.id_valid & bus.id_src_used[i] & t_valid[j] & t_wb_en[j]
                            & (bus.id_src[i*REG_AW +: REG_AW] == t_dest[j]);
            end
        end
    end

    always_comb begin
        stall_any = 1'b0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (j < STALL_DEPTH) begin
                    stall_any = stall_any | (match[i][j] & (t_is_load[j] | !FWD_EN));
                end
            end
        end
    end

    assign bus.hazard_stall = ~bus.flush & stall_any;
    assign insert           = bus.id_valid & ~bus.hazard_stall & ~bus.flush;

    // Tag shift register; a stalled or flushed slot enters EXE as an invalid bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            t_valid   <= '0;
            t_wb_en   <= '0;
            t_is_load <= '0;
            t_dest    <= '0;
        end else if (!bus.freeze) begin
            t_valid[0]   <= insert;
            t_wb_en[0]   <= bus.id_wb_en;
            t_is_load[0] <= bus.id_mem_read;
            t_dest[0]    <= bus.id_dest;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                t_valid[k]   <= t_valid[k-1];
                t_wb_en[k]   <= t_wb_en[k-1];
                t_is_load[k] <= t_is_load[k-1];
                t_dest[k]    <= t_dest[k-1];
            end
        end
    end

`ifdef HAZARD_FWD_EN
    localparam int unsigned SW = $clog2(DEPTH + 1);

    logic [N_SRC-1:0][SW-1:0] sel_nxt;
    logic [N_SRC-1:0][SW-1:0] sel_q;

    // Scan oldest to youngest so the youngest matching producer is kept
    always_comb begin
        sel_nxt = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            for (int unsigned j = DEPTH; j > 0; j--) begin
                if (match[i][j-1]) begin
                    sel_nxt[i] = SW'(j);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q <= '0;
        end else if (!bus.freeze) begin
            sel_q <= insert ? sel_nxt : '0;
        end
    end

    assign bus.exe_sel = sel_q;
`else
    assign bus.exe_sel = '0;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed vector table, then random traffic vs. an in-flight list model.
// Expectations follow the HAZARD_FWD_EN setting of the build.
module tb_fwd_hazard_unit;
    localparam int unsigned REG_AW   = 4;
    localparam int unsigned N_SRC    = 3;
    localparam int unsigned DEPTH    = 2;
    localparam int unsigned LOAD_LAT = 1;
    localparam int unsigned SW       = $clog2(DEPTH + 1);
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        bit                      rst;
        bit                      frz;
        bit                      fl;
        bit                      vld;
        logic [N_SRC*REG_AW-1:0] src;
        logic [N_SRC-1:0]        used;
        logic [REG_AW-1:0]       dest;
        bit                      wb;
        bit                      ld;
        bit                      st_f;
        logic [N_SRC*SW-1:0]     sel_f;
        bit                      st_n;
    } vec_t;

    // One in-flight producer; age = pipeline stage index (0 = EXE)
    typedef struct {
        logic [REG_AW-1:0] dest;
        bit                wb;
        bit                ld;
        int unsigned       age;
    } rec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fwd_hazard_if #(.REG_AW(REG_AW), .N_SRC(N_SRC), .DEPTH(DEPTH)) bus();

    fwd_hazard_unit #(.REG_AW(REG_AW), .N_SRC(N_SRC), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    vec_t tbl[$];
    rec_t flight[$];
    logic [N_SRC*SW-1:0] m_sel;

    task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s #%0d: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(bit r, bit fz, bit fl, bit vv, int s0, int s1, logic [2:0] u,
                                int d, bit wb, bit ld, bit sf, int sel, bit sn);
        vec_t x;
        x.rst = r;  x.frz = fz; x.fl = fl; x.vld = vv;
        x.src  = {4'd0, 4'(s1), 4'(s0)};
        x.used = u; x.dest = 4'(d); x.wb = wb; x.ld = ld;
        x.st_f = sf; x.sel_f = 6'(sel); x.st_n = sn;
        return x;
    endfunction

    task automatic drive(input vec_t x);
        rst             = x.rst;
        bus.freeze      = x.frz;
        bus.flush       = x.fl;
        bus.id_valid    = x.vld;
        bus.id_src      = x.src;
        bus.id_src_used = x.used;
        bus.id_dest     = x.dest;
        bus.id_wb_en    = x.wb;
        bus.id_mem_read = x.ld;
    endtask

    function automatic bit m_hit(input vec_t x, input int unsigned i, input rec_t p);
        logic [N_SRC*REG_AW-1:0] s;
        s = x.src;
        return x.vld && x.used[i] && p.wb && (p.dest == s[i*REG_AW +: REG_AW]);
    endfunction

    // Load-use (or any RAW without bypassing) on a producer not yet forwardable
    function automatic bit m_stall(input vec_t x);
        bit hit;
        hit = 1'b0;
        if (x.fl) return 1'b0;
        foreach (flight[r]) begin
            for (int unsigned i = 0; i < N_SRC; i++) begin
                if (m_hit(x, i, flight[r]) && (!FWD || (flight[r].ld && flight[r].age < LOAD_LAT)))
                    hit = 1'b1;
            end
        end
        return hit;
    endfunction

    task automatic m_clock(input vec_t x, input bit st);
        logic [N_SRC*SW-1:0] nsel;
        rec_t keep[$];
        rec_t nw;
        bit ins;
        int unsigned best;
        nsel = '0;
        if (x.rst) begin
            flight.delete();
            m_sel = '0;
            return;
        end
        if (x.frz) return;
        ins = x.vld && !st && !x.fl;
        if (ins && FWD) begin
            for (int unsigned i = 0; i < N_SRC; i++) begin
                best = DEPTH;
                foreach (flight[r])
                    if (m_hit(x, i, flight[r]) && flight[r].age < best) best = flight[r].age;
                if (best < DEPTH) nsel[i*SW +: SW] = SW'(best + 1);
            end
        end
        foreach (flight[r]) begin
            flight[r].age++;
            if (flight[r].age < DEPTH) keep.push_back(flight[r]);
        end
        flight = keep;
        if (ins) begin
            nw.dest = x.dest; nw.wb = x.wb; nw.ld = x.ld; nw.age = 0;
            flight.push_front(nw);
        end
        m_sel = nsel;
    endtask

    initial begin
        vec_t x;
        bit est;
        // rst frz fl v  s0 s1 used  dest wb ld | stall_fwd sel_fwd stall_nofwd
        tbl.push_back(mk(1,0,0,0, 0,0,3'b000, 0, 0,0, 0,'h00,0));  // 0 reset
        tbl.push_back(mk(0,0,0,1, 2,3,3'b011, 1, 1,0, 0,'h00,0));  // 1 ADD r1
        tbl.push_back(mk(0,0,0,1, 1,3,3'b011, 2, 1,0, 0,'h01,1));  // 2 ADD r2,r1,r3
        tbl.push_back(mk(0,0,0,1, 1,3,3'b011, 2, 1,0, 0,'h02,1));
        tbl.push_back(mk(0,0,0,1, 1,3,3'b011, 2, 1,0, 0,'h00,0));
        tbl.push_back(mk(1,0,0,0, 0,0,3'b000, 0, 0,0, 0,'h00,0));  // 5 reset
        tbl.push_back(mk(0,0,0,1, 2,3,3'b011, 1, 1,0, 0,'h00,0));  // ADD r1
        tbl.push_back(mk(0,0,0,0, 0,0,3'b000, 0, 0,0, 0,'h00,0));  // NOP
        tbl.push_back(mk(0,0,0,1, 1,1,3'b011, 4, 1,0, 0,'h0A,1));  // SUB r4,r1,r1
        tbl.push_back(mk(1,0,0,0, 0,0,3'b000, 0, 0,0, 0,'h00,0));  // 9 reset
        tbl.push_back(mk(0,0,0,1, 2,0,3'b001, 5, 1,1, 0,'h00,0));  // LDR r5
        tbl.push_back(mk(0,0,0,1, 5,0,3'b001, 6, 1,0, 1,'h00,1));  // ADD r6,r5,#1
        tbl.push_back(mk(0,0,0,1, 5,0,3'b001, 6, 1,0, 0,'h02,1));
        tbl.push_back(mk(0,0,0,0, 0,0,3'b000, 0, 0,0, 0,'h00,0));
        tbl.push_back(mk(1,0,0,0, 0,0,3'b000, 0, 0,0, 0,'h00,0));  // 14 reset
        tbl.push_back(mk(0,0,0,1, 2,3,3'b011, 1, 1,0, 0,'h00,0));  // ADD r1
        tbl.push_back(mk(0,0,0,1, 2,3,3'b011, 1, 1,0, 0,'h00,0));  // ADD r1
        tbl.push_back(mk(0,0,0,1, 1,1,3'b001, 2, 1,0, 0,'h01,1));  // MOV r2,r1 (op1 unused)
        tbl.push_back(mk(1,0,0,0, 0,0,3'b000, 0, 0,0, 0,'h00,0));  // 18 reset
        tbl.push_back(mk(0,0,0,1, 2,3,3'b011, 1, 1,0, 0,'h00,0));
        tbl.push_back(mk(0,0,0,1, 1,3,3'b011, 2, 1,0, 0,'h01,1));
        tbl.push_back(mk(0,1,0,0, 0,0,3'b000, 0, 0,0, 0,'h01,0));  // freeze x3
        tbl.push_back(mk(0,1,0,0, 0,0,3'b000, 0, 0,0, 0,'h01,0));
        tbl.push_back(mk(0,1,0,0, 0,0,3'b000, 0, 0,0, 0,'h01,0));
        tbl.push_back(mk(0,0,0,1, 1,2,3'b011, 7, 1,0, 0,'h06,1));  // ADD r7,r1,r2
        tbl.push_back(mk(1,0,0,0, 0,0,3'b000, 0, 0,0, 0,'h00,0));  // 25 reset
        tbl.push_back(mk(0,0,0,1, 2,0,3'b001, 5, 1,1, 0,'h00,0));  // LDR r5
        tbl.push_back(mk(0,1,0,1, 5,0,3'b001, 6, 1,0, 1,'h00,1));  // stall under freeze
        tbl.push_back(mk(0,0,1,1, 5,0,3'b001, 6, 1,0, 0,'h00,0));  // flush kills stall
        tbl.push_back(mk(0,0,0,1, 5,0,3'b001, 6, 1,0, 0,'h02,1));
        tbl.push_back(mk(0,0,0,1, 2,3,3'b011, 8, 1,0, 0,'h00,0));
        tbl.push_back(mk(0,0,0,1, 8,0,3'b001, 9, 1,0, 0,'h01,1));
        tbl.push_back(mk(1,0,0,1, 8,0,3'b001, 9, 1,0, 0,'h00,1));  // reset mid-stall
        tbl.push_back(mk(0,0,0,1, 8,0,3'b001, 9, 1,0, 0,'h00,0));
        tbl.push_back(mk(0,0,0,1, 2,3,3'b011, 1, 0,0, 0,'h00,0));  // CMP: wb_en=0
        tbl.push_back(mk(0,0,0,1, 1,9,3'b011,10, 1,0, 0,'h08,1));

        drive(mk(1,0,0,0, 0,0,3'b000, 0, 0,0, 0,0,0));
        repeat (2) @(posedge clk);
        #1;

        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k]);
            #1;
            check("stall", k, 8'(bus.hazard_stall), 8'(FWD ? tbl[k].st_f : tbl[k].st_n));
            @(posedge clk);
            #1;
            check("exe_sel", k, 8'(bus.exe_sel), FWD ? 8'(tbl[k].sel_f) : 8'h00);
        end

        x = mk(1,0,0,0, 0,0,3'b000, 0, 0,0, 0,0,0);
        drive(x);
        m_clock(x, 1'b0);
        @(posedge clk);
        #1;

        for (int c = 0; c < 3000; c++) begin
            x.rst  = ($urandom_range(63) == 0);
            x.frz  = ($urandom_range(7) == 0);
            x.fl   = ($urandom_range(7) == 0);
            x.vld  = ($urandom_range(3) != 0);
            x.src  = {4'($urandom_range(3)), 4'($urandom_range(3)), 4'($urandom_range(3))};
            x.used = 3'($urandom);
            x.dest = 4'($urandom_range(3));
            x.wb   = ($urandom_range(4) != 0);
            x.ld   = ($urandom_range(2) == 0);
            drive(x);
            #1;
            est = m_stall(x);
            check("rnd_stall", c, 8'(bus.hazard_stall), 8'(est));
            m_clock(x, est);
            @(posedge clk);
            #1;
            check("rnd_exe_sel", c, 8'(bus.exe_sel), 8'(m_sel));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
